control_unit_mc: RTL and testbench
==================================

// Module: control_unit_mc
// PURPOSE
//  Parametrised multicycle control FSM for the miniMIPS datapath. It accepts one instruction
//  per valid/ready handshake and reads operands from the register file using a ready handshake.
//  It selects the ALU operands and code for R-type, shift and ADDI forms, and waits for the ALU
//  to finish (with a timeout) before issuing a single-cycle register-file write.
//  The block sits between the instruction source and the register file/ALU pair.
// PARAMETERS
//  DATA_WIDTH    32  width of register data and ALU operands
//  CODE_WIDTH    6   width of OpCode, Funct and ALU_Code
//  SHAMT_WIDTH   5   width of the shift amount field
//  NOP_OPCODE    63  OpCode accepted and discarded
//  ADDI_OPCODE   8   I-type add OpCode; its ALU code is ADD_CODE
//  ADD_CODE      32  ALU_Code driven for ADDI (6'h20)
//  ALU_TIMEOUT   15  maximum EXE cycles without ALU_DONE (>=1)
//  CNT_WIDTH     16  width of INSTR_COUNT
// PORTS
//  CLK          in   1            clock, rising edge
//  RST          in   1            asynchronous reset, active low
//  INSTR_VALID  in   1            instruction fields below are valid
//  INSTR_READY  out  1            FSM can accept (1 iff state==FETCH)
//  OpCode       in   CODE_WIDTH   instruction opcode
//  Funct        in   CODE_WIDTH   R-type function code
//  Shamt        in   SHAMT_WIDTH  shift amount
//  Imm          in   16           I-type immediate
//  DATA_R1      in   DATA_WIDTH   register-file read port 1
//  DATA_R2      in   DATA_WIDTH   register-file read port 2
//  RF_READY     in   1            read data valid while READ=1
//  ALU_DONE     in   1            ALU result valid
//  READ         out  1            register-file read request
//  WRITE        out  1            register-file write strobe (1 cycle)
//  ALU_START    out  1            1-cycle pulse on entry to EXE
//  ALU_OP1      out  DATA_WIDTH   ALU operand 1
//  ALU_OP2      out  DATA_WIDTH   ALU operand 2
//  ALU_Code     out  CODE_WIDTH   ALU operation code
//  DONE         out  1            1-cycle pulse; instruction retired
//  ILLEGAL      out  1            1-cycle pulse; unsupported opcode/funct dropped
//  ERR          out  1            sticky ALU timeout flag
//  INSTR_COUNT  out  CNT_WIDTH    retired-instruction counter
// BEHAVIOUR
//  - Reset (RST=0, any time, async): state=FETCH. Outputs READ, WRITE, ALU_START, DONE, ILLEGAL,
//    ERR, ALU_OP1, ALU_OP2, ALU_Code and INSTR_COUNT are all 0. Any in-flight instruction is
//    dropped with no WRITE.
//  - States: FETCH -> RD -> EXE -> WB -> FETCH. All outputs except INSTR_READY are registered.
//  - Transfer: an instruction is accepted on a rising edge with INSTR_VALID & INSTR_READY.
//    OpCode/Funct/Shamt/Imm are latched internally at that edge.
//  - FETCH, accepted NOP_OPCODE: stay in FETCH; no other output changes.
//  - FETCH, accepted supported instruction: go to RD; READ=1 from the next cycle.
//    Supported instructions: OpCode 0 (any Funct), or ADDI_OPCODE.
//  - FETCH, accepted anything else: stay in FETCH; ILLEGAL=1 for the next cycle.
//  - RD: hold READ=1 until RF_READY is sampled 1. At that edge go to EXE: READ=0, ALU_START=1
//    (1 cycle), and load the operands:
//      OpCode 0, Funct 1 or 2: OP1=DATA_R1, OP2=zero-extended Shamt, Code=Funct.
//      OpCode 0, other Funct:  OP1=DATA_R1, OP2=DATA_R2, Code=Funct.
//      ADDI:                   OP1=DATA_R1, OP2=sign-extended Imm to DATA_WIDTH, Code=ADD_CODE.
//  - EXE:
//      ALU_DONE sampled 1 -> WB (this includes the ALU_START cycle).
//      Otherwise an internal counter increments. When ALU_TIMEOUT cycles pass with no done:
//      set ERR, go to FETCH, no WRITE, no DONE. ALU_DONE wins over timeout in the same cycle.
//  - WB: exactly one cycle with WRITE=1 and DONE=1. INSTR_COUNT increments and wraps at
//    2^CNT_WIDTH-1 -> 0. Next state is FETCH.
//  - Operand regs hold their value until the next RD->EXE transfer.
//  - ERR clears only on reset. Operation continues normally after ERR is set.
//  - Minimum latency: acceptance edge +3 cycles to WRITE (RF_READY and ALU_DONE both immediate).
// TESTING
//  - Reset, then R-type Funct=6'h20, R1=5, R2=7, RF_READY/ALU_DONE immediate
//    -> OP1=5, OP2=7, Code=6'h20; WRITE and DONE for 1 cycle 3 cycles after accept; COUNT=1.
//  - Funct=6'h01, Shamt=3, R2=99 -> OP2=3. ADDI Imm=16'hFFFE -> OP2=32'hFFFFFFFE, Code=6'h20.
//  - RF_READY held low 4 cycles -> READ high for 5 cycles; ALU_START pulses once after.
//  - NOP (63) then OpCode 5 -> no READ; ILLEGAL pulses once; INSTR_READY stays 1; COUNT unchanged.
//  - ALU_DONE never -> ERR=1 after 15 EXE cycles, no WRITE; next instruction retires normally.
//  - RST pulsed low in EXE -> all outputs 0, no WRITE; CNT_WIDTH=2, 5 retires -> COUNT=1.

Source files
------------

// File: rtl/control_unit_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : control_unit_mc                                              |
// | Description : Multicycle control FSM for the miniMIPS datapath.            |
// |               Accepts one instruction per valid/ready handshake, reads     |
// |               operands from the register file, drives ALU operands/code    |
// |               for R-type, shift and ADDI forms, waits for the ALU (with a  |
// |               timeout) and issues a single-cycle register-file write.      |
// | Ports       : CLK/RST (async, active low); INSTR_VALID/INSTR_READY plus    |
// |               OpCode/Funct/Shamt/Imm instruction fields; DATA_R1/DATA_R2/  |
// |               RF_READY/READ register-file read side; WRITE write strobe;   |
// |               ALU_START/ALU_OP1/ALU_OP2/ALU_Code/ALU_DONE ALU side;        |
// |               DONE/ILLEGAL pulses, ERR sticky timeout, INSTR_COUNT.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module control_unit_mc #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    CODE_WIDTH  = 6,
   parameter int                    SHAMT_WIDTH = 5,
   parameter logic [CODE_WIDTH-1:0] NOP_OPCODE  = CODE_WIDTH'(63),
   parameter logic [CODE_WIDTH-1:0] ADDI_OPCODE = CODE_WIDTH'(8),
   parameter logic [CODE_WIDTH-1:0] ADD_CODE    = CODE_WIDTH'(32),
   parameter int                    ALU_TIMEOUT = 15,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   INSTR_VALID,
   output logic                   INSTR_READY,
   input  logic [CODE_WIDTH-1:0]  OpCode,
   input  logic [CODE_WIDTH-1:0]  Funct,
   input  logic [SHAMT_WIDTH-1:0] Shamt,
   input  logic [15:0]            Imm,
   input  logic [DATA_WIDTH-1:0]  DATA_R1,
   input  logic [DATA_WIDTH-1:0]  DATA_R2,
   input  logic                   RF_READY,
   input  logic                   ALU_DONE,
   output logic                   READ,
   output logic                   WRITE,
   output logic                   ALU_START,
   output logic [DATA_WIDTH-1:0]  ALU_OP1,
   output logic [DATA_WIDTH-1:0]  ALU_OP2,
   output logic [CODE_WIDTH-1:0]  ALU_Code,
   output logic                   DONE,
   output logic                   ILLEGAL,
   output logic                   ERR,
   output logic [CNT_WIDTH-1:0]   INSTR_COUNT
);

   localparam int                 TMO_W    = $clog2(ALU_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      RD    = 2'd1,
      EXE   = 2'd2,
      WB    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic                   read_q, read_d;
   logic                   write_q, write_d;
   logic                   start_q, start_d;
   logic                   done_q, done_d;
   logic                   illegal_q, illegal_d;
   logic                   err_q, err_d;
   logic [DATA_WIDTH-1:0]  op1_q, op1_d;
   logic [DATA_WIDTH-1:0]  op2_q, op2_d;
   logic [CODE_WIDTH-1:0]  code_q, code_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [CODE_WIDTH-1:0]  opc_q, opc_d;
   logic [CODE_WIDTH-1:0]  funct_q, funct_d;
   logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
   logic [15:0]            imm_q, imm_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= FETCH;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         err_q     <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         code_q    <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         opc_q     <= '0;
         funct_q   <= '0;
         shamt_q   <= '0;
         imm_q     <= '0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         start_q   <= start_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         err_q     <= err_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         opc_q     <= opc_d;
         funct_q   <= funct_d;
         shamt_q   <= shamt_d;
         imm_q     <= imm_d;
      end
   end

   always_comb begin
      // Pulse outputs default low; everything else holds.
      state_d   = state_q;
      read_d    = 1'b0;
      write_d   = 1'b0;
      start_d   = 1'b0;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      err_d     = err_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      opc_d     = opc_q;
      funct_d   = funct_q;
      shamt_d   = shamt_q;
      imm_d     = imm_q;

      case (state_q)
         FETCH: begin
            if (INSTR_VALID) begin
               opc_d   = OpCode;
               funct_d = Funct;
               shamt_d = Shamt;
               imm_d   = Imm;
               if (OpCode == NOP_OPCODE) begin
                  state_d = FETCH;
               end else if (OpCode == '0 || OpCode == ADDI_OPCODE) begin
                  state_d = RD;
                  read_d  = 1'b1;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         RD: begin
            if (RF_READY) begin
               state_d = EXE;
               start_d = 1'b1;
               tmo_d   = '0;
               op1_d   = DATA_R1;
               if (opc_q == ADDI_OPCODE) begin
                  op2_d  = {{(DATA_WIDTH-16){imm_q[15]}}, imm_q};
                  code_d = ADD_CODE;
               end else if (funct_q == CODE_WIDTH'(1) || funct_q == CODE_WIDTH'(2)) begin
                  // Immediate shifts take the amount from the instruction, not R2.
                  op2_d  = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, shamt_q};
                  code_d = funct_q;
               end else begin
                  op2_d  = DATA_R2;
                  code_d = funct_q;
               end
            end else begin
               read_d = 1'b1;
            end
         end
         EXE: begin
            // ALU_DONE takes priority over an expiring timeout.
            if (ALU_DONE) begin
               state_d = WB;
               write_d = 1'b1;
               done_d  = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               state_d = FETCH;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         WB: begin
            state_d = FETCH;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   assign INSTR_READY = (state_q == FETCH);
   assign READ        = read_q;
   assign WRITE       = write_q;
   assign ALU_START   = start_q;
   assign DONE        = done_q;
   assign ILLEGAL     = illegal_q;
   assign ERR         = err_q;
   assign ALU_OP1     = op1_q;
   assign ALU_OP2     = op2_q;
   assign ALU_Code    = code_q;
   assign INSTR_COUNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_control_unit_mc                                           |
// | Description : Self-checking bench for control_unit_mc. Expected ALU        |
// |               operands/code are queued when an instruction is issued and   |
// |               popped when the DUT raises WRITE. A second instance with a   |
// |               2-bit counter shares all inputs to exercise counter wrap.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_control_unit_mc;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        INSTR_VALID = 1'b0;
   logic [5:0]  OpCode = '0;
   logic [5:0]  Funct = '0;
   logic [4:0]  Shamt = '0;
   logic [15:0] Imm = '0;
   logic [31:0] DATA_R1 = '0;
   logic [31:0] DATA_R2 = '0;
   logic        RF_READY = 1'b1;
   logic        ALU_DONE = 1'b1;

   logic        INSTR_READY, READ, WRITE, ALU_START, DONE, ILLEGAL, ERR;
   logic [31:0] ALU_OP1, ALU_OP2;
   logic [5:0]  ALU_Code;
   logic [15:0] INSTR_COUNT;

   logic        d2_ready, d2_read, d2_write, d2_start, d2_done, d2_illegal, d2_err;
   logic [31:0] d2_op1, d2_op2;
   logic [5:0]  d2_code;
   logic [1:0]  d2_count;

   control_unit_mc dut (
      .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .OpCode(OpCode), .Funct(Funct), .Shamt(Shamt), .Imm(Imm),
      .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .RF_READY(RF_READY), .ALU_DONE(ALU_DONE),
      .READ(READ), .WRITE(WRITE), .ALU_START(ALU_START), .ALU_OP1(ALU_OP1),
      .ALU_OP2(ALU_OP2), .ALU_Code(ALU_Code), .DONE(DONE), .ILLEGAL(ILLEGAL),
      .ERR(ERR), .INSTR_COUNT(INSTR_COUNT)
   );

   control_unit_mc #(.CNT_WIDTH(2)) dut2 (
      .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR_READY(d2_ready),
      .OpCode(OpCode), .Funct(Funct), .Shamt(Shamt), .Imm(Imm),
      .DATA_R1(DATA_R1), .DATA_R2(DATA_R2), .RF_READY(RF_READY), .ALU_DONE(ALU_DONE),
      .READ(d2_read), .WRITE(d2_write), .ALU_START(d2_start), .ALU_OP1(d2_op1),
      .ALU_OP2(d2_op2), .ALU_Code(d2_code), .DONE(d2_done), .ILLEGAL(d2_illegal),
      .ERR(d2_err), .INSTR_COUNT(d2_count)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [5:0]  code;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   writes = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] op1, input logic [31:0] op2, input logic [5:0] code);
      exp_t e;
      e.op1  = op1;
      e.op2  = op2;
      e.code = code;
      sb.push_back(e);
   endtask

   // Scoreboard consumer: every write must match the oldest queued expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (RST === 1'b1 && WRITE === 1'b1) begin
         writes++;
         chk("write_has_expectation", (sb.size() != 0), 1);
         chk("wb_done", DONE, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_op1", ALU_OP1, e.op1);
            chk("wb_op2", ALU_OP2, e.op2);
            chk("wb_code", ALU_Code, e.code);
         end
      end
   end

   // Drives one instruction on a negedge and returns at the negedge after acceptance.
   task automatic issue(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [15:0] im);
      int n;
      n = 0;
      @(negedge CLK);
      while (INSTR_READY !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_before_issue", INSTR_READY, 1);
      OpCode      = opc;
      Funct       = fn;
      Shamt       = sh;
      Imm         = im;
      INSTR_VALID = 1'b1;
      @(posedge CLK);
      #1 INSTR_VALID = 1'b0;
      @(negedge CLK);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk(tag, DONE, 1);
      @(negedge CLK);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_read"}, READ, 0);
      chk({tag, "_write"}, WRITE, 0);
      chk({tag, "_start"}, ALU_START, 0);
      chk({tag, "_done"}, DONE, 0);
      chk({tag, "_illegal"}, ILLEGAL, 0);
      chk({tag, "_err"}, ERR, 0);
      chk({tag, "_op1"}, ALU_OP1, 0);
      chk({tag, "_op2"}, ALU_OP2, 0);
      chk({tag, "_code"}, ALU_Code, 0);
      chk({tag, "_count"}, INSTR_COUNT, 0);
      chk({tag, "_count2"}, d2_count, 0);
      chk({tag, "_ready"}, INSTR_READY, 1);
   endtask

   initial begin
      int read_cnt;
      int start_cnt;
      int w0;

      // Reset
      #1 RST = 1'b0;
      @(negedge CLK);
      check_reset("reset");
      #3 RST = 1'b1;

      // Basic R-type add, immediate handshakes
      DATA_R1 = 32'd5;
      DATA_R2 = 32'd7;
      push(32'd5, 32'd7, 6'h20);
      issue(6'd0, 6'h20, 5'd0, 16'd0);
      chk("c1_read", READ, 1);
      chk("c1_start", ALU_START, 0);
      chk("c1_ready", INSTR_READY, 0);
      @(negedge CLK);
      chk("c2_start", ALU_START, 1);
      chk("c2_read", READ, 0);
      chk("c2_op1", ALU_OP1, 32'd5);
      chk("c2_op2", ALU_OP2, 32'd7);
      chk("c2_code", ALU_Code, 6'h20);
      chk("c2_write", WRITE, 0);
      @(negedge CLK);
      chk("c3_write", WRITE, 1);
      chk("c3_done", DONE, 1);
      @(negedge CLK);
      chk("c4_write", WRITE, 0);
      chk("c4_done", DONE, 0);
      chk("c4_count", INSTR_COUNT, 1);
      chk("c4_ready", INSTR_READY, 1);

      // Shift forms use Shamt, ADDI sign-extends Imm, other funct uses R2
      DATA_R1 = 32'h11;
      DATA_R2 = 32'd99;
      push(32'h11, 32'd3, 6'h01);
      issue(6'd0, 6'h01, 5'd3, 16'd0);
      wait_done("sll_done");
      DATA_R1 = 32'h8000_0000;
      push(32'h8000_0000, 32'd31, 6'h02);
      issue(6'd0, 6'h02, 5'd31, 16'hFFFF);
      wait_done("srl_done");
      DATA_R1 = 32'd100;
      DATA_R2 = 32'd30;
      push(32'd100, 32'd30, 6'h22);
      issue(6'd0, 6'h22, 5'd7, 16'd0);
      wait_done("sub_done");
      DATA_R1 = 32'd10;
      DATA_R2 = 32'd55;
      push(32'd10, 32'hFFFF_FFFE, 6'h20);
      issue(6'd8, 6'h3F, 5'd9, 16'hFFFE);
      wait_done("addi_neg_done");
      push(32'd10, 32'h0000_1234, 6'h20);
      issue(6'd8, 6'h01, 5'd4, 16'h1234);
      wait_done("addi_pos_done");
      chk("count_after_forms", INSTR_COUNT, 6);

      // RF_READY held low for 4 cycles
      RF_READY = 1'b0;
      DATA_R1  = 32'd1;
      DATA_R2  = 32'd2;
      push(32'd1, 32'd2, 6'h24);
      issue(6'd0, 6'h24, 5'd0, 16'd0);
      read_cnt  = 0;
      start_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         read_cnt  += int'(READ);
         start_cnt += int'(ALU_START);
         if (i == 5) RF_READY = 1'b1;
         @(negedge CLK);
      end
      chk("rf_wait_read_cycles", read_cnt, 5);
      chk("rf_wait_start_pulses", start_cnt, 1);
      chk("count_after_rf_wait", INSTR_COUNT, 7);

      // NOP discarded, unsupported opcode flagged
      issue(6'd63, 6'h20, 5'd0, 16'd0);
      chk("nop_read", READ, 0);
      chk("nop_ready", INSTR_READY, 1);
      chk("nop_illegal", ILLEGAL, 0);
      issue(6'd5, 6'h20, 5'd0, 16'd0);
      chk("ill_pulse", ILLEGAL, 1);
      chk("ill_read", READ, 0);
      chk("ill_ready", INSTR_READY, 1);
      @(negedge CLK);
      chk("ill_pulse_end", ILLEGAL, 0);
      chk("ill_count", INSTR_COUNT, 7);

      // ALU timeout
      ALU_DONE = 1'b0;
      w0 = writes;
      issue(6'd0, 6'h20, 5'd0, 16'd0);
      repeat (15) @(negedge CLK);
      chk("tmo_err_early", ERR, 0);
      @(negedge CLK);
      chk("tmo_err", ERR, 1);
      chk("tmo_ready", INSTR_READY, 1);
      chk("tmo_no_write", writes, w0);
      chk("tmo_count", INSTR_COUNT, 7);
      ALU_DONE = 1'b1;
      DATA_R1  = 32'd40;
      DATA_R2  = 32'd2;
      push(32'd40, 32'd2, 6'h21);
      issue(6'd0, 6'h21, 5'd0, 16'd0);
      wait_done("after_tmo_done");
      chk("err_sticky", ERR, 1);
      chk("after_tmo_count", INSTR_COUNT, 8);

      // Reset in EXE drops the instruction
      ALU_DONE = 1'b0;
      w0 = writes;
      issue(6'd0, 6'h20, 5'd0, 16'd0);
      @(negedge CLK);
      chk("rst_exe_start", ALU_START, 1);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_reset("rst_exe");
      #12 RST = 1'b1;
      ALU_DONE = 1'b1;
      chk("rst_exe_no_write", writes, w0);

      // Counter wrap on the 2-bit instance
      for (int i = 0; i < 5; i++) begin
         DATA_R1 = 32'(i);
         DATA_R2 = 32'(i * 3);
         push(32'(i), 32'(i * 3), 6'h25);
         issue(6'd0, 6'h25, 5'd0, 16'd0);
         wait_done("wrap_done");
      end
      chk("wrap_count2", d2_count, 1);
      chk("wrap_count16", INSTR_COUNT, 5);

      @(negedge CLK);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
